// File: rtl/rev_serial_alu.sv
// Bit-serial ADD/SUB/AND/XOR ALU built on a reversible Toffoli/CNOT bit cell, LSB first; optional garbage port via REV_GARBAGE_OUT_EN.
// Latency: WIDTH+1 cycles from the accept edge to out_valid (WIDTH bit cycles plus one settle cycle).
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE and never looks at out_ready.

module rev_toffoli (
    input  logic x1,
    input  logic x2,
    input  logic x3,
    output logic y3
);
    assign y3 = (x1 & x2) ^ x3;
endmodule

module rev_cnot (
    input  logic x1,
    input  logic x2,
    output logic y2
);
    assign y2 = x1 ^ x2;
endmodule

// One reversible full-adder slice; g and p double as the AND and XOR results.
module rev_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic g_o,
    output logic p_o,
    output logic c_o,
    output logic s_o
);
    rev_toffoli u_gen  (.x1(a_i), .x2(b_i), .x3(1'b0), .y3(g_o));
    rev_cnot    u_prop (.x1(a_i), .x2(b_i),             .y2(p_o));
    // g and p&c are never both 1, so the XOR into g acts as the carry OR.
    rev_toffoli u_cry  (.x1(p_o), .x2(c_i), .x3(g_o),  .y3(c_o));
    rev_cnot    u_sum  (.x1(p_o), .x2(c_i),             .y2(s_o));
endmodule

module rev_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef REV_GARBAGE_OUT_EN
    output logic [WIDTH-1:0] garbage,
`endif
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
`ifdef REV_GARBAGE_OUT_EN
    logic [WIDTH-1:0] garb_q, garb_d;
`endif

    logic cell_g, cell_p, cell_c, cell_s;
    logic bit_res;
    logic is_arith;

    rev_bit_cell u_cell (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .g_o (cell_g),
        .p_o (cell_p),
        .c_o (cell_c),
        .s_o (cell_s)
    );

    assign is_arith = ~op_q[1];

    always_comb begin
        bit_res = cell_s;
        unique case (op_q)
            OP_AND:  bit_res = cell_g;
            OP_XOR:  bit_res = cell_p;
            default: bit_res = cell_s;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
`ifdef REV_GARBAGE_OUT_EN
        garb_d  = garb_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    // Subtraction is a + ~b + 1: invert here, carry-in supplies the +1.
                    b_d     = (op == OP_SUB) ? ~b : b;
                    op_d    = op;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = (op == OP_SUB);
                    ovf_d   = 1'b0;
`ifdef REV_GARBAGE_OUT_EN
                    garb_d  = '0;
`endif
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = DONE;
                end else begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    res_d = {bit_res, res_q[WIDTH-1:1]};
`ifdef REV_GARBAGE_OUT_EN
                    garb_d = {cell_p, garb_q[WIDTH-1:1]};
`endif
                    if (is_arith) begin
                        carry_d = cell_c;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            ovf_d = carry_q ^ cell_c;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef REV_GARBAGE_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            garb_q <= '0;
        end else begin
            garb_q <= garb_d;
        end
    end

    assign garbage = garb_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign cout      = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rev_serial_alu.sv
// Scoreboard bench for rev_serial_alu (WIDTH=8): directed vectors, backpressure hold, async abort, random ops.
module tb_rev_serial_alu;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic [W-1:0] garb;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
`ifdef REV_GARBAGE_OUT_EN
    logic [W-1:0] garbage;
`endif

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    rev_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
`ifdef REV_GARBAGE_OUT_EN
        .garbage   (garbage),
`endif
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, want);
        end else begin
            n_pass++;
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] yb;
        logic [W:0]   s;
        exp_t         e;
        yb     = (o == 2'b01) ? ~y : y;
        e.garb = x ^ yb;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        e.res  = '0;
        case (o)
            2'b00, 2'b01: begin
                s      = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, (o == 2'b01)};
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (x[W-1] == yb[W-1]) && (e.res[W-1] != x[W-1]);
            end
            2'b10:   e.res = x & y;
            default: e.res = x ^ y;
        endcase
        return e;
    endfunction

    // Called on a negedge while idle; returns on the negedge right after the accept edge.
    task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        check("in_ready_idle", {31'b0, in_ready}, 1);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv();
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        check("latency", n, W + 1);
        check("in_ready_busy", {31'b0, in_ready}, 0);
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("result", {24'b0, result}, {24'b0, e.res});
        check("cout", {31'b0, cout}, {31'b0, e.cout});
        check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`ifdef REV_GARBAGE_OUT_EN
        check("garbage", {24'b0, garbage}, {24'b0, e.garb});
`endif
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        send(o, x, y, e);
        recv();
        @(negedge clk);
        check("ack_clears_valid", {31'b0, out_valid}, 0);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] rx, ry;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_result", {24'b0, result}, 0);
        check("rst_cout", {31'b0, cout}, 0);
        check("rst_ovf", {31'b0, ovf}, 0);
`ifdef REV_GARBAGE_OUT_EN
        check("rst_garbage", {24'b0, garbage}, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 1);

        run_op(2'b00, 8'h7F, 8'h01, '{res: 8'h80, cout: 1'b0, ovf: 1'b1, garb: 8'h7E});
        run_op(2'b01, 8'h05, 8'h07, '{res: 8'hFE, cout: 1'b0, ovf: 1'b0, garb: 8'hFD});
        run_op(2'b01, 8'h07, 8'h05, '{res: 8'h02, cout: 1'b1, ovf: 1'b0, garb: 8'hFD});
        run_op(2'b10, 8'hF0, 8'h3C, '{res: 8'h30, cout: 1'b0, ovf: 1'b0, garb: 8'hCC});
        run_op(2'b11, 8'hF0, 8'h3C, '{res: 8'hCC, cout: 1'b0, ovf: 1'b0, garb: 8'hCC});
        run_op(2'b00, 8'hAA, 8'h0F, '{res: 8'hB9, cout: 1'b0, ovf: 1'b0, garb: 8'hA5});

        // Hold result under backpressure while new operands are offered.
        out_ready = 1'b0;
        send(2'b10, 8'hF0, 8'h3C, '{res: 8'h30, cout: 1'b0, ovf: 1'b0, garb: 8'hCC});
        in_valid = 1'b1;
        op       = 2'b00;
        a        = 8'h11;
        b        = 8'h22;
        recv();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_result", {24'b0, result}, 32'h30);
            check("hold_in_ready", {31'b0, in_ready}, 0);
        end
        sb.push_back('{res: 8'h33, cout: 1'b0, ovf: 1'b0, garb: 8'h33});
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_release_idle", {31'b0, in_ready}, 1);
        check("hold_release_valid", {31'b0, out_valid}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        recv();
        @(negedge clk);
        check("ack_clears_valid", {31'b0, out_valid}, 0);

        // Asynchronous abort partway through RUN.
        in_valid = 1'b1;
        op       = 2'b00;
        a        = 8'h12;
        b        = 8'h34;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", {31'b0, in_ready}, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 0);
        check("abort_in_ready", {31'b0, in_ready}, 1);
        check("abort_result", {24'b0, result}, 0);
        check("abort_cout", {31'b0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 8'hFF, 8'h01, '{res: 8'h00, cout: 1'b1, ovf: 1'b0, garb: 8'hFE});

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = W'($urandom);
            ry = W'($urandom);
            run_op(ro, rx, ry, model(ro, rx, ry));
        end

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rev_serial_alu.md
REV_SERIAL_ALU -- requirements
Module: rev_serial_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block accepts operands (high only in IDLE).
REQ-006 op  input  2  00=ADD, 01=SUB, 10=AND, 11=XOR; sampled on accept.
REQ-007 a, b  input  WIDTH each  operands; sampled on accept.
REQ-008 out_valid  output  1  result held and valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 result  output  WIDTH  computed word.
REQ-011 cout  output  1  final carry of ADD/SUB (0 for AND/XOR).
REQ-012 ovf  output  1  signed overflow of ADD/SUB (0 for AND/XOR).

Function
REQ-013 Block SHALL be a bit-serial operand sequencer feeding one reversible cell per cycle, LSB first.
REQ-014 Per-bit cell SHALL be built only from Toffoli (y3=(x1&x2)^x3) and CNOT (y2=x1^x2) gate instances; no other logic in the datapath bit slice.
REQ-015 AND SHALL use one Toffoli with target 0; XOR one CNOT; ADD/SUB a Toffoli+CNOT full adder with carry held in a 1-bit register.
REQ-016 SUB SHALL be a + ~b + 1: b inverted at load, carry register preset to 1.
REQ-017 FSM SHALL have states IDLE, RUN, DONE.
REQ-018 IDLE -> RUN on in_valid & in_ready; a, b, op latched into shift registers, bit counter cleared, carry preset (1 for SUB, else 0).
REQ-019 RUN SHALL process exactly one bit per cycle, shifting the result bit in at the MSB end; after WIDTH cycles -> DONE.
REQ-020 Latency SHALL be WIDTH+1 cycles from accept edge to out_valid high.
REQ-021 DONE SHALL hold out_valid=1 and result/cout/ovf stable until out_valid & out_ready; then -> IDLE in the same edge.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid there is ignored, no operand overwrite.
REQ-023 in_ready SHALL NOT combinationally depend on out_ready (no IDLE bypass in the handshake edge).
REQ-024 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB; cout the final carry register value.
REQ-025 Bit counter SHALL be ceil(log2(WIDTH+1)) wide; no wrap before the WIDTH-th bit.

Reset
REQ-026 rst_n low SHALL force IDLE immediately, independent of clk.
REQ-027 Reset values: in_ready=1 after release, out_valid=0, result=0, cout=0, ovf=0, carry=0, counter=0.
REQ-028 Reset during RUN or DONE SHALL abort the operation; no partial result is ever presented with out_valid=1.

Configuration
REQ-029 Macro REV_GARBAGE_OUT_EN SHALL control a garbage observation port.
REQ-030 Defined: extra output garbage, WIDTH bits, holding the per-bit propagate lines (a_i^b_i after SUB inversion) captured alongside result, valid with out_valid, reset to 0.
REQ-031 Undefined: port and its register absent; all other behaviour identical.

Verification
REQ-032 WIDTH=8, ADD a=0x7F b=0x01, out_ready=1 -> out_valid at cycle 9 after accept, result=0x80, cout=0, ovf=1.
REQ-033 SUB a=0x05 b=0x07 -> result=0xFE, cout=0, ovf=0; SUB a=0x07 b=0x05 -> result=0x02, cout=1.
REQ-034 AND 0xF0,0x3C -> 0x30; XOR 0xF0,0x3C -> 0xCC; cout=ovf=0 for both.
REQ-035 out_ready held 0 for 5 cycles in DONE with in_valid=1 and new operands -> result stable, in_ready=0, new operands not taken; accept occurs only after return to IDLE.
REQ-036 rst_n asserted at RUN bit 4 -> state IDLE, out_valid=0 without clock edge; next op ADD 0xFF+0x01 -> result=0x00, cout=1.
REQ-037 With REV_GARBAGE_OUT_EN, ADD 0xAA+0x0F -> garbage=0xA5; build without macro compiles and passes REQ-032..036.
